// File: rtl/interrupt_scheduler_if.sv
// Request/instruction bundle between the input pins, the frame divider and the CPU.
// The scheduler sits on the slave side of this interface.
interface interrupt_scheduler_if;
   logic        frame_tick;
   logic        jump_key;
   logic        restart_req;
   logic        frame_en;
   logic [31:0] interrupt_instruction;
   logic        irq_busy;
   logic [1:0]  irq_source;
   logic [7:0]  dropped_count;

   modport master (
      output frame_tick, jump_key, restart_req, frame_en,
      input  interrupt_instruction, irq_busy, irq_source, dropped_count
   );

   modport slave (
      input  frame_tick, jump_key, restart_req, frame_en,
      output interrupt_instruction, irq_busy, irq_source, dropped_count
   );
endinterface

// File: rtl/interrupt_scheduler.sv
// Injects restart/jump/frame instructions into the CPU one at a time, each followed by a holdoff.
// Optional jump_key debounce filter is enabled with `define DEBOUNCE_EN.
module interrupt_scheduler #(
   parameter logic [31:0] RESTART_INSTR   = 32'h0800_0003,
   parameter logic [31:0] JUMP_INSTR      = 32'h0800_0002,
   parameter logic [31:0] FRAME_INSTR     = 32'h0800_0001,
   parameter int unsigned HOLDOFF_CYCLES  = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   interrupt_scheduler_if.slave  bus
);

   if (HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
      $error("HOLDOFF_CYCLES out of range 0..255");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 1..65535");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StHoldoff} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic        busy_q, busy_d;
   logic [1:0]  src_q, src_d;
   logic [7:0]  drop_q, drop_d;
   logic [2:0]  prev_q, prev_d;   // {restart, jump, frame}
   logic [2:0]  pend_q, pend_d;
   logic [2:0]  req, clr, coal;
   logic [9:0]  drop_sum;
   logic        jump_lvl;

`ifdef DEBOUNCE_EN
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic        jump_filt_q, jump_filt_d;

   // Filtered level follows the raw key only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      deb_cnt_d   = '0;
      jump_filt_d = jump_filt_q;
      if (bus.jump_key != jump_filt_q) begin
         if (deb_cnt_q == 16'(DEBOUNCE_CYCLES - 1)) begin
            jump_filt_d = bus.jump_key;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_cnt_q   <= '0;
         jump_filt_q <= 1'b1;
      end else begin
         deb_cnt_q   <= deb_cnt_d;
         jump_filt_q <= jump_filt_d;
      end
   end

   assign jump_lvl = jump_filt_q;
`else
   assign jump_lvl = bus.jump_key;
`endif

   assign prev_d = {bus.restart_req, jump_lvl, bus.frame_tick};
   assign req[0] = bus.frame_tick & ~prev_q[0] & bus.frame_en;
   assign req[1] = jump_lvl & ~prev_q[1];
   assign req[2] = bus.restart_req & ~prev_q[2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = '0;
      busy_d  = busy_q;
      src_d   = src_q;
      clr     = '0;
      unique case (state_q)
         StIdle: begin
            busy_d = 1'b0;
            if (|pend_q) begin
               state_d = StIssue;
               busy_d  = 1'b1;
               if (pend_q[2]) begin
                  clr     = 3'b100;
                  instr_d = RESTART_INSTR;
                  src_d   = 2'd3;
               end else if (pend_q[1]) begin
                  clr     = 3'b010;
                  instr_d = JUMP_INSTR;
                  src_d   = 2'd2;
               end else begin
                  clr     = 3'b001;
                  instr_d = FRAME_INSTR;
                  src_d   = 2'd1;
               end
            end
         end
         StIssue: begin
            if (HOLDOFF_CYCLES == 0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               state_d = StHoldoff;
               cnt_d   = 8'(HOLDOFF_CYCLES - 1);
               busy_d  = 1'b1;
            end
         end
         StHoldoff: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A request landing on the cycle its flag is consumed re-arms the flag rather than coalescing.
   assign pend_d   = (pend_q & ~clr) | req;
   assign coal     = req & pend_q & ~clr;
   assign drop_sum = {2'b00, drop_q} + 10'(coal[0]) + 10'(coal[1]) + 10'(coal[2]);
   assign drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         instr_q <= '0;
         busy_q  <= 1'b0;
         src_q   <= '0;
         drop_q  <= '0;
         prev_q  <= 3'b111;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         busy_q  <= busy_d;
         src_q   <= src_d;
         drop_q  <= drop_d;
         prev_q  <= prev_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.interrupt_instruction = instr_q;
   assign bus.irq_busy              = busy_q;
   assign bus.irq_source            = src_q;
   assign bus.dropped_count         = drop_q;

endmodule
